// File: rtl/cafu_log_arb.sv
// cafu_log_arb: shares the single log-line packer / AXI write path between
// NUM_SRC AXI-stream capture sources. A source is granted for a whole line of
// BEATS_PER_LINE beats, so each log line carries beats from exactly one source,
// tagged with its index. A granted source that stalls mid-line has the rest of
// its line padded. Per-source beat counters and a pad counter are kept.
//
// Ports
//   clk, rst     clock, asynchronous active-high reset
//   arb_enable   allow new grants (a line in progress always completes)
//   src_mask     1 = source excluded from arbitration
//   s_tvalid     per-source valid
//   s_tdata      per-source data, source i at [i*DATA_W +: DATA_W]
//   s_tready     per-source ready
//   m_tvalid     to packer: valid
//   m_tdata      to packer: data (0 on pad beats)
//   m_tready     from packer: ready
//   m_tsrc       granted source index
//   m_tfirst     first beat of line
//   m_tlast      last beat of line
//   m_tpad       beat is padding, not source data
//   stat_beats   per-source accepted-beat counters, source i at [i*64 +: 64]
//   stat_pads    total pad beats emitted
module cafu_log_arb #(
    parameter int unsigned NUM_SRC        = 4,
    parameter int unsigned DATA_W         = 72,
    parameter int unsigned BEATS_PER_LINE = 7,
    parameter int unsigned IDLE_TIMEOUT   = 64,
    parameter int unsigned SRC_W          = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       arb_enable,
    input  logic [NUM_SRC-1:0]         src_mask,
    input  logic [NUM_SRC-1:0]         s_tvalid,
    input  logic [NUM_SRC*DATA_W-1:0]  s_tdata,
    output logic [NUM_SRC-1:0]         s_tready,
    output logic                       m_tvalid,
    output logic [DATA_W-1:0]          m_tdata,
    input  logic                       m_tready,
    output logic [SRC_W-1:0]           m_tsrc,
    output logic                       m_tfirst,
    output logic                       m_tlast,
    output logic                       m_tpad,
    output logic [NUM_SRC*64-1:0]      stat_beats,
    output logic [63:0]                stat_pads
);

    localparam int unsigned BEAT_W  = (BEATS_PER_LINE > 1) ? $clog2(BEATS_PER_LINE) : 1;
    localparam int unsigned STALL_W = $clog2(IDLE_TIMEOUT + 1);
    localparam int unsigned STAT_W  = 64;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_PAD   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [SRC_W-1:0]     grant_q, grant_d;
    logic [SRC_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [BEAT_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic [STALL_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic [NUM_SRC-1:0]   req;
    logic [SRC_W-1:0]     pick;
    logic [SRC_W-1:0]     cand;
    logic [SRC_W-1:0]     next_ptr;
    logic                 g_valid;
    logic [DATA_W-1:0]    g_data;
    logic                 first_beat;
    logic                 last_beat;
    logic                 data_acc;
    logic                 pad_acc;

    logic [STAT_W-1:0]    beats_q [NUM_SRC];
    logic [STAT_W-1:0]    pads_q;

    // Requesters eligible for a new grant
    assign req = s_tvalid & ~src_mask & {NUM_SRC{arb_enable}};

    // Round-robin pick: scan offsets high to low so the nearest requester at or
    // after rr_ptr is the last one written.
    always_comb begin
        pick = rr_ptr_q;
        cand = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            cand = SRC_W'((32'(rr_ptr_q) + (NUM_SRC - 1 - k)) % NUM_SRC);
            if (req[cand]) begin
                pick = cand;
            end
        end
    end

    // Granted source's stream
    assign g_valid = s_tvalid[grant_q];

    always_comb begin
        g_data = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (grant_q == SRC_W'(k)) begin
                g_data = s_tdata[k*DATA_W +: DATA_W];
            end
        end
    end

    assign next_ptr   = (32'(grant_q) == NUM_SRC - 1) ? '0 : grant_q + SRC_W'(1);
    assign first_beat = (beat_cnt_q == '0);
    assign last_beat  = (beat_cnt_q == BEAT_W'(BEATS_PER_LINE - 1));

    // Next-state and stream outputs
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        beat_cnt_d  = beat_cnt_q;
        stall_cnt_d = stall_cnt_q;
        m_tvalid    = 1'b0;
        m_tdata     = '0;
        s_tready    = '0;
        m_tsrc      = '0;
        m_tfirst    = 1'b0;
        m_tlast     = 1'b0;
        m_tpad      = 1'b0;
        data_acc    = 1'b0;
        pad_acc     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (|req) begin
                    grant_d     = pick;
                    beat_cnt_d  = '0;
                    stall_cnt_d = '0;
                    state_d     = S_GRANT;
                end
            end

            S_GRANT: begin
                m_tvalid          = g_valid;
                m_tdata           = g_data;
                s_tready[grant_q] = m_tready;
                m_tsrc            = grant_q;
                m_tfirst          = first_beat;
                m_tlast           = last_beat;
                if (g_valid && m_tready) begin
                    data_acc    = 1'b1;
                    stall_cnt_d = '0;
                    if (last_beat) begin
                        beat_cnt_d = '0;
                        rr_ptr_d   = next_ptr;
                        state_d    = S_IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                    end
                end else if (!g_valid) begin
                    // Only an absent source counts as a stall; packer backpressure does not.
                    stall_cnt_d = stall_cnt_q + STALL_W'(1);
                    if (stall_cnt_q == STALL_W'(IDLE_TIMEOUT - 1)) begin
                        state_d = S_PAD;
                    end
                end
            end

            S_PAD: begin
                m_tvalid = 1'b1;
                m_tpad   = 1'b1;
                m_tsrc   = grant_q;
                m_tfirst = first_beat;
                m_tlast  = last_beat;
                if (m_tready) begin
                    pad_acc = 1'b1;
                    if (last_beat) begin
                        beat_cnt_d = '0;
                        rr_ptr_d   = next_ptr;
                        state_d    = S_IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM and line-position registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            beat_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            beat_cnt_q  <= beat_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Statistics, wrapping modulo 2^64
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < NUM_SRC; k++) begin
                beats_q[k] <= '0;
            end
            pads_q <= '0;
        end else begin
            if (data_acc) begin
                beats_q[grant_q] <= beats_q[grant_q] + STAT_W'(1);
            end
            if (pad_acc) begin
                pads_q <= pads_q + STAT_W'(1);
            end
        end
    end

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_stat
        assign stat_beats[gi*STAT_W +: STAT_W] = beats_q[gi];
    end

    assign stat_pads = pads_q;

endmodule

// File: tb/tb_cafu_log_arb.sv
// tb_cafu_log_arb: directed scenarios with randomized source valid / packer
// ready, checked against a transaction-level model of line structure, source
// data ordering, grant order and beat/pad statistics.
module tb_cafu_log_arb;

    localparam int unsigned NS  = 4;
    localparam int unsigned DW  = 72;
    localparam int unsigned BPL = 7;
    localparam int unsigned TO  = 64;
    localparam int unsigned SW  = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            arb_enable;
    logic [NS-1:0]   src_mask;
    logic [NS-1:0]   s_tvalid;
    logic [NS*DW-1:0] s_tdata;
    logic [NS-1:0]   s_tready;
    logic            m_tvalid;
    logic [DW-1:0]   m_tdata;
    logic            m_tready;
    logic [SW-1:0]   m_tsrc;
    logic            m_tfirst;
    logic            m_tlast;
    logic            m_tpad;
    logic [NS*64-1:0] stat_beats;
    logic [63:0]     stat_pads;

    always #5 clk = ~clk;

    cafu_log_arb #(
        .NUM_SRC(NS), .DATA_W(DW), .BEATS_PER_LINE(BPL), .IDLE_TIMEOUT(TO), .SRC_W(SW)
    ) dut (
        .clk(clk), .rst(rst), .arb_enable(arb_enable), .src_mask(src_mask),
        .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tready(s_tready),
        .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tready(m_tready),
        .m_tsrc(m_tsrc), .m_tfirst(m_tfirst), .m_tlast(m_tlast), .m_tpad(m_tpad),
        .stat_beats(stat_beats), .stat_pads(stat_pads)
    );

    int unsigned     tests;
    int unsigned     fails;

    // Source generators
    int              src_left [NS];   // beats still to offer, -1 = unlimited
    int unsigned     src_prob [NS];   // % chance to raise valid when idle
    longint unsigned src_seq  [NS];   // next sequence number to offer
    int unsigned     ready_prob;
    logic [NS-1:0]   hs_src;

    // Reference model
    longint unsigned exp_seq   [NS];  // next sequence expected at the output
    longint unsigned exp_beats [NS];
    longint unsigned exp_pads;
    int unsigned     line_pos;
    int unsigned     line_src;
    bit              pad_in_line;
    int unsigned     lines_done;
    int unsigned     hs_total;
    int unsigned     pads_seen;
    int unsigned     cyc;
    int unsigned     last_data_cyc;
    int unsigned     first_pad_cyc;
    int              chk_mode;        // 0 none, 1 fixed source, 2 round-robin, 3 next line only
    int unsigned     chk_src;
    bit              prev_stall;
    logic [DW-1:0]   prev_data;
    logic [SW-1:0]   prev_src;
    logic            prev_pad;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] want);
        tests++;
        assert (obs === want) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_tvalid"}, m_tvalid, 0);
        check({tag, "_tdata"}, m_tdata, 0);
        check({tag, "_s_tready"}, s_tready, 0);
        check({tag, "_tsrc"}, m_tsrc, 0);
        check({tag, "_tfirst"}, m_tfirst, 0);
        check({tag, "_tlast"}, m_tlast, 0);
        check({tag, "_tpad"}, m_tpad, 0);
        check({tag, "_stat_beats"}, stat_beats, 0);
        check({tag, "_stat_pads"}, stat_pads, 0);
    endtask

    task automatic clear_model();
        for (int i = 0; i < NS; i++) exp_beats[i] = 0;
        exp_pads    = 0;
        line_pos    = 0;
        pad_in_line = 1'b0;
        prev_stall  = 1'b0;
        hs_src      = '0;
        chk_mode    = 0;
    endtask

    // Observe one cycle before its active edge
    task automatic monitor();
        logic [NS*64-1:0] beats_vec;
        logic [NS-1:0]    exp_hs;
        cyc++;
        for (int i = 0; i < NS; i++) beats_vec[i*64 +: 64] = exp_beats[i];
        check("stat_beats", stat_beats, beats_vec);
        check("stat_pads", stat_pads, exp_pads);
        if (prev_stall) begin
            check("hold_tvalid", m_tvalid, 1);
            check("hold_tdata", m_tdata, prev_data);
            check("hold_tsrc", m_tsrc, prev_src);
            check("hold_tpad", m_tpad, prev_pad);
        end
        hs_src = s_tvalid & s_tready;
        exp_hs = '0;
        if (m_tvalid && m_tready && !m_tpad) exp_hs[m_tsrc] = 1'b1;
        check("src_handshake", hs_src, exp_hs);
        if (m_tvalid && m_tready) begin
            hs_total++;
            check("tfirst", m_tfirst, line_pos == 0);
            check("tlast", m_tlast, line_pos == BPL - 1);
            if (line_pos == 0) begin
                line_src    = 32'(m_tsrc);
                pad_in_line = 1'b0;
                check("grant_unmasked", src_mask[m_tsrc], 0);
                if (chk_mode != 0) begin
                    check("grant_src", m_tsrc, chk_src);
                    if (chk_mode == 2) chk_src = (chk_src + 1) % NS;
                    else if (chk_mode == 3) chk_mode = 0;
                end
            end else begin
                check("tsrc_in_line", m_tsrc, line_src);
            end
            if (m_tpad) begin
                if (!pad_in_line) first_pad_cyc = cyc;
                check("pad_tdata", m_tdata, 0);
                exp_pads++;
                pads_seen++;
                pad_in_line = 1'b1;
            end else begin
                check("data_after_pad", pad_in_line, 0);
                check("beat_data", m_tdata, {8'(m_tsrc), exp_seq[m_tsrc]});
                exp_seq[m_tsrc]++;
                exp_beats[m_tsrc]++;
                last_data_cyc = cyc;
            end
            line_pos = (line_pos + 1) % BPL;
            if (line_pos == 0) lines_done++;
        end
        prev_stall = m_tvalid && !m_tready;
        prev_data  = m_tdata;
        prev_src   = m_tsrc;
        prev_pad   = m_tpad;
    endtask

    // AXI-compliant sources: valid held until accepted
    task automatic drive();
        for (int i = 0; i < NS; i++) begin
            if (hs_src[i]) begin
                s_tvalid[i] = 1'b0;
                src_seq[i]++;
                if (src_left[i] > 0) src_left[i]--;
            end
            if (!s_tvalid[i] && src_left[i] != 0 && $urandom_range(99) < src_prob[i]) begin
                s_tvalid[i] = 1'b1;
                s_tdata[i*DW +: DW] = {8'(i), src_seq[i]};
            end
        end
        m_tready = ($urandom_range(99) < ready_prob);
        hs_src = '0;
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic run_lines(input string tag, input int unsigned n, input int unsigned budget);
        int unsigned target = lines_done + n;
        int unsigned k = 0;
        while (lines_done < target && k < budget) begin
            step();
            k++;
        end
        check({tag, "_lines"}, lines_done, target);
    endtask

    task automatic wait_pos(input string tag, input int unsigned pos, input int unsigned budget);
        int unsigned k = 0;
        while (line_pos != pos && k < budget) begin
            step();
            k++;
        end
        check({tag, "_line_pos"}, line_pos, pos);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        s_tvalid   = '0;
        s_tdata    = '0;
        arb_enable = 1'b1;
        src_mask   = '0;
        m_tready   = 1'b1;
        ready_prob = 100;
        for (int i = 0; i < NS; i++) begin
            src_left[i] = 0;
            src_prob[i] = 100;
        end
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned h0;
        int unsigned p0;
        logic [63:0] tot;

        tests = 0; fails = 0; cyc = 0; lines_done = 0; hs_total = 0; pads_seen = 0;
        last_data_cyc = 0; first_pad_cyc = 0; line_src = 0; chk_src = 0;
        prev_data = '0; prev_src = '0; prev_pad = 1'b0;
        for (int i = 0; i < NS; i++) begin
            src_seq[i] = 0;
            exp_seq[i] = 0;
        end
        rst = 1'b1; arb_enable = 1'b1; src_mask = '0; s_tvalid = '0; s_tdata = '0; m_tready = 1'b0;

        // Single source: two full lines from src0
        do_reset();
        src_left[0] = 14;
        chk_mode = 1; chk_src = 0;
        h0 = hs_total;
        run_lines("single", 2, 60);
        step();
        step();
        check("single_hs", hs_total - h0, 14);
        check("single_stat", stat_beats[63:0], 14);

        // Round-robin over four always-valid sources
        do_reset();
        for (int i = 0; i < NS; i++) src_left[i] = -1;
        chk_mode = 2; chk_src = 0;
        run_lines("rr", 8, 120);
        step();
        for (int i = 0; i < NS; i++) check("rr_stat", stat_beats[i*64 +: 64], 14);

        // Pad: src2 gives three beats then goes quiet
        do_reset();
        src_left[2] = 3;
        chk_mode = 1; chk_src = 2;
        p0 = pads_seen;
        run_lines("pad", 1, 150);
        step();
        check("pad_count", pads_seen - p0, 4);
        check("pad_gap", first_pad_cyc - last_data_cyc, TO + 1);
        check("pad_stat_pads", stat_pads, 4);
        check("pad_stat_beats2", stat_beats[2*64 +: 64], 3);

        // Backpressure: random packer ready, bursty src1
        do_reset();
        src_left[1] = -1; src_prob[1] = 70; ready_prob = 50;
        chk_mode = 1; chk_src = 1;
        run_lines("bp", 6, 600);
        check("bp_no_pad", stat_pads, 0);
        check("bp_beats", stat_beats[64 +: 64], 6 * BPL);

        // Random mix of all sources and packer ready
        do_reset();
        for (int i = 0; i < NS; i++) begin
            src_left[i] = -1;
            src_prob[i] = 60;
        end
        ready_prob = 70;
        run_lines("mix", 12, 2000);
        tot = stat_pads;
        for (int i = 0; i < NS; i++) tot = tot + stat_beats[i*64 +: 64];
        check("mix_total", tot, 12 * BPL);

        // Mask src1, then disable arbitration mid-line
        do_reset();
        src_mask = 4'b0010;
        for (int i = 0; i < NS; i++) src_left[i] = -1;
        run_lines("mask", 4, 100);
        wait_pos("en", 3, 20);
        arb_enable = 1'b0;
        run_lines("en_finish", 1, 20);
        h0 = hs_total;
        repeat (30) step();
        check("en_no_grant", hs_total - h0, 0);
        check("mask_src1_beats", stat_beats[64 +: 64], 0);

        // Reset in the middle of src1's line
        do_reset();
        for (int i = 0; i < NS; i++) src_left[i] = -1;
        run_lines("rst_pre", 1, 30);
        wait_pos("rst_mid", 4, 30);
        rst = 1'b1;
        #1;
        check_zero("midrst");
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_mode = 3; chk_src = 0;
        run_lines("rst_post", 1, 30);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
